// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: word width, the j opcode,
// the fetch FSM state encoding and the j-target helper.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [5:0] OPC_J = 6'b000010;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_IDLE,
    S_DROP
  } fetch_state_t;

  // j target: upper nibble of the delay-slot address, 26-bit index, word aligned
  function automatic logic [WORD_W-1:0] jump_target(input logic [3:0] pc_hi,
                                                    input logic [25:0] index);
    return {pc_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for a fetched instruction and its PC+4.
// Catches an ack that arrives while IF/ID is stalled. Clear wins over
// load, load wins over drain.
module if_skid_buffer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [WORD_W-1:0] load_inst,
  input  logic [WORD_W-1:0] load_pc,
  output logic              full,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] pc
);

  // Occupancy and payload of the single entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      inst <= '0;
      pc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      inst <= load_inst;
      pc   <= load_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake and feeds IF/ID with inst, PC+4 and a valid flag.
// Optional: define IF_JUMP_PREDECODE_EN to follow j instructions directly
// from the fetched word instead of waiting for a redirect from ID.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [WORD_W-1:0] imem_rdata_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] inst_o,
  output logic [WORD_W-1:0] pc_o
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] drop_addr_q;
  logic              valid_q;
  logic [WORD_W-1:0] inst_q;
  logic [WORD_W-1:0] pc_out_q;

  logic              skid_full;
  logic [WORD_W-1:0] skid_inst;
  logic [WORD_W-1:0] skid_pc;

  logic              slot_free;
  logic              ack_take;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_next_full;
  logic [WORD_W-1:0] fetch_pc_plus4;
  logic [WORD_W-1:0] next_seq_pc;
  logic [WORD_W-1:0] redirect_addr;

  // A dropped request keeps presenting its original address until acked
  assign imem_req_o  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr_o = (state == S_DROP) ? drop_addr_q : pc_q;

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_out_q;

  assign fetch_pc_plus4 = pc_q + 32'd4;
  assign redirect_addr  = redirect_pc_i & ~32'h3;

  // Output slot can accept a word if empty or if IF/ID is advancing
  assign slot_free  = !valid_q || !stall_i;
  // Ack data that belongs to the current (correct) path
  assign ack_take   = (state == S_REQ) && imem_ack_i && !redirect_i;
  assign skid_drain = slot_free && skid_full && !redirect_i;
  assign skid_load  = ack_take && (!slot_free || skid_full);
  assign skid_next_full = !redirect_i && (skid_load || (skid_full && !skid_drain));

`ifdef IF_JUMP_PREDECODE_EN
  assign next_seq_pc = (imem_rdata_i[31:26] == OPC_J)
                     ? jump_target(fetch_pc_plus4[31:28], imem_rdata_i[25:0])
                     : fetch_pc_plus4;
`else
  assign next_seq_pc = fetch_pc_plus4;
`endif

  if_skid_buffer u_skid (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clear     (redirect_i),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_inst (imem_rdata_i),
    .load_pc   (fetch_pc_plus4),
    .full      (skid_full),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

  // Fetch FSM: PC ownership, request sequencing and wrong-path drop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_BOOT;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect_i) pc_q <= redirect_addr;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_i) begin
            pc_q <= redirect_addr;
            if (!imem_ack_i) begin
              drop_addr_q <= pc_q;
              state       <= S_DROP;
            end
          end else if (imem_ack_i) begin
            pc_q  <= next_seq_pc;
            state <= skid_next_full ? S_IDLE : S_REQ;
          end
        end
        S_IDLE: begin
          if (redirect_i) begin
            pc_q  <= redirect_addr;
            state <= S_REQ;
          end else if (!skid_next_full) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect_i) pc_q <= redirect_addr;
          if (imem_ack_i) state <= S_REQ;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  // IF/ID-facing registers: flush on redirect, hold while stalled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      inst_q   <= NOP_INST;
      pc_out_q <= '0;
    end else if (redirect_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (slot_free) begin
      if (skid_full) begin
        valid_q  <= 1'b1;
        inst_q   <= skid_inst;
        pc_out_q <= skid_pc;
      end else if (ack_take) begin
        valid_q  <= 1'b1;
        inst_q   <= imem_rdata_i;
        pc_out_q <= fetch_pc_plus4;
      end else begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit. The reference model is an
// instruction-stream view: every word IF/ID accepts must be the next
// program-order instruction, restarting at the target after a redirect.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (ack),
    .imem_rdata_i  (rdata),
    .valid_o       (valid),
    .inst_o        (inst),
    .pc_o          (pc_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_pc;
  int          lat_mode;
  bit          mem_busy;
  int          mem_wait;
  bit          hold_pending;
  logic [31:0] hold_inst, hold_pc;
  bit          addr_pending;
  logic [31:0] held_addr;
  int          n_consumed = 0;
  int          idle_cycles = 0;

  // Program image: a j at 0x10 targeting 0x100, loads elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0800_0040;
    return {6'b100011, a[27:2]};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] a4;
    w  = mem_word(a);
    a4 = a + 32'd4;
`ifdef IF_JUMP_PREDECODE_EN
    if (w[31:26] == 6'b000010) return {a4[31:28], w[25:0], 2'b00};
`endif
    return a4;
  endfunction

  // One clock: check current outputs, drive inputs, advance the model.
  // Called at a negedge, returns at the next negedge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit consumed;
    if (!valid) check("nop_when_invalid", inst, NOP);
    if (hold_pending) begin
      check("hold_valid", valid, 1);
      check("hold_inst", inst, hold_inst);
      check("hold_pc", pc_out, hold_pc);
    end
    if (addr_pending) begin
      check("req_kept", imem_req, 1);
      check("addr_stable", imem_addr, held_addr);
    end
    if (imem_req) check("addr_aligned", imem_addr & 32'h3, 0);

    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (mem_wait == 0) begin
        ack = 1;
        rdata = mem_word(imem_addr);
      end else begin
        ack = 0;
        rdata = $urandom;
        mem_wait--;
      end
    end else begin
      ack = 0;
    end

    hold_pending = valid && st && !rd;
    hold_inst    = inst;
    hold_pc      = pc_out;
    addr_pending = imem_req && !ack;
    held_addr    = imem_addr;
    if (ack) mem_busy = 0;

    consumed = valid && !st && !rd;
    idle_cycles++;
    if (rd) begin
      exp_pc = rpc & ~32'h3;
      idle_cycles = 0;
    end else if (consumed) begin
      $display("txn pc_o=%h inst=%h", pc_out, inst);
      check("stream_inst", inst, mem_word(exp_pc));
      check("stream_pc", pc_out, exp_pc + 32'd4);
      exp_pc = next_pc(exp_pc);
      n_consumed++;
      idle_cycles = 0;
    end
    if (idle_cycles > 300) begin
      check("liveness", idle_cycles, 0);
      idle_cycles = 0;
    end
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check the asynchronous reset values, release
  task automatic do_reset();
    rst_n = 0;
    stall = 0;
    redirect = 0;
    ack = 0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_inst", inst, NOP);
    check("rst_pc", pc_out, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1;
    mem_busy = 0;
    hold_pending = 0;
    addr_pending = 0;
    exp_pc = RESET_PC;
    idle_cycles = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_after_j;
    @(negedge clk);

    // Zero-wait memory, no stall: back-to-back fetches
    lat_mode = 0;
    do_reset();
    check("t1_boot_req", imem_req, 0);
    step(0, 0, 0);
    check("t1_req0", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", valid, 0);
    step(0, 0, 0);
    check("t1_addr1", imem_addr, 32'h4);
    check("t1_valid1", valid, 1);
    check("t1_pc1", pc_out, 32'h4);
    step(0, 0, 0);
    check("t1_addr2", imem_addr, 32'h8);
    check("t1_pc2", pc_out, 32'h8);

    // Stall 3 cycles with an ack landing: skid captures, req drops
    step(1, 0, 0);
    check("t2_idle_req_a", imem_req, 0);
    step(1, 0, 0);
    check("t2_idle_req_b", imem_req, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("t2_skid_out_valid", valid, 1);
    check("t2_skid_out_pc", pc_out, 32'hC);
    repeat (4) step(0, 0, 0);

    // 3-cycle memory, redirect on first wait cycle
    lat_mode = 3;
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h100);
    check("t3_addr_hold", imem_addr, 32'h0);
    check("t3_req_hold", imem_req, 1);
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr != 32'h0) break;
      step(0, 0, 0);
    end
    check("t3_new_addr", imem_addr, 32'h100);
    repeat (10) step(0, 0, 0);

    // Redirect together with ack and stall
    lat_mode = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid && imem_req) break;
      step(0, 0, 0);
    end
    check("t4_pre_valid", valid, 1);
    step(1, 1, 32'h200);
    check("t4_valid", valid, 0);
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h200);
    repeat (6) step(0, 0, 0);

    // Reset in the middle of a waiting request
    lat_mode = 3;
    repeat (6) step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (addr_pending) break;
      step(0, 0, 0);
    end
    do_reset();
    step(0, 0, 0);
    check("t5_first_req", imem_req, 1);
    check("t5_first_addr", imem_addr, RESET_PC);

    // j at 0x10: predecoded target or plain +4
    lat_mode = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_addr == 32'h10) break;
      step(0, 0, 0);
    end
    check("t6_at_10", imem_addr, 32'h10);
    step(0, 0, 0);
`ifdef IF_JUMP_PREDECODE_EN
    exp_after_j = 32'h100;
`else
    exp_after_j = 32'h14;
`endif
    check("t6_next_addr", imem_addr, exp_after_j);
    check("t6_j_valid", valid, 1);
    check("t6_j_pc", pc_out, 32'h14);
    step(0, 0, 0);
    check("t6_no_bubble", valid, 1);
    check("t6_after_j_pc", pc_out, exp_after_j + 32'd4);

    // Randomised traffic: stalls, redirects, variable latency
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, $urandom_range(0, 1023));
    end
    check("progress", n_consumed > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
